// File: rtl/mano_mem_axi_bridge.sv
// AXI4-Lite slave giving the PS indirect, arbitrated access to BRAM banks shared with the Mano CPU.
// Optional feature macro MANO_BRIDGE_PERF_EN: cpu_run cycle counter readable at offset 0x14.
module mano_mem_axi_bridge #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 12,
  parameter int NUM_BANKS          = 2,
  parameter int RD_LATENCY         = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0] mem_addr,
  output logic [NUM_BANKS-1:0]            mem_ce,
  output logic [NUM_BANKS-1:0]            mem_we,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] mem_d,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] mem_q,
  input  logic                            cpu_ce,
  input  logic                            cpu_we,
  input  logic [ADDR_WIDTH-1:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0]           cpu_d,
  output logic [DATA_WIDTH-1:0]           cpu_q,
  output logic                            mano_cpu_reset_n,
  output logic [2:0]                      dbg_state
);

  typedef enum logic [2:0] {IDLE, WR_ARB, RD_ARB, RD_LAT, RESP} state_t;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_ADDR   = 3'd1;
  localparam logic [2:0] OFF_WDATA  = 3'd2;
  localparam logic [2:0] OFF_RDATA  = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_PERF   = 3'd5;
  localparam logic [1:0] OKAY       = 2'b00;
  localparam logic [1:0] SLVERR     = 2'b10;

  state_t                  state, state_nxt;
  logic                    cpu_run, auto_inc, op_rd, sticky;
  logic [3:0]              cpu_bank, bank_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg, ps_q;
  logic [7:0]              coll_cnt;
  logic [1:0]              lat_cnt;
  logic [31:0]             reg_rdata, perf_val;
  logic [2:0]              wr_off, rd_off;
  logic                    wr_accept, rd_accept, bank_ok, collision, ps_grant, lat_done;
  logic                    unused_inputs;

  // Handshake: a channel transfers on a cycle where valid & ready are both high. awready/wready and
  // arready are single-cycle strobes derived from the incoming valids; bvalid/rvalid are registered
  // and hold until the matching bready/rready. A write wins a same-cycle tie with a read.
  assign wr_accept       = s00_axi_awvalid && s00_axi_wvalid && (state == IDLE) && !s00_axi_bvalid;
  assign rd_accept       = s00_axi_arvalid && (state == IDLE) && !s00_axi_rvalid && !wr_accept;
  assign s00_axi_awready = wr_accept;
  assign s00_axi_wready  = wr_accept;
  assign s00_axi_arready = rd_accept;

  assign wr_off        = s00_axi_awaddr[4:2];
  assign rd_off        = s00_axi_araddr[4:2];
  assign bank_ok       = int'(bank_reg) < NUM_BANKS;
  assign collision     = cpu_run && cpu_ce && (bank_reg == cpu_bank);
  assign ps_grant      = ((state == WR_ARB) || (state == RD_ARB)) && !collision;
  assign lat_done      = (lat_cnt == 2'(RD_LATENCY - 1));
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign mano_cpu_reset_n = cpu_run;
  assign dbg_state        = state;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) state <= IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_accept && wr_off == OFF_WDATA && bank_ok)      state_nxt = WR_ARB;
        else if (rd_accept && rd_off == OFF_RDATA && bank_ok) state_nxt = RD_ARB;
      end
      WR_ARB: if (!collision) state_nxt = RESP;
      RD_ARB: if (!collision) state_nxt = RD_LAT;
      RD_LAT: if (lat_done)   state_nxt = RESP;
      RESP: begin
        if (op_rd ? (s00_axi_rvalid && s00_axi_rready) : (s00_axi_bvalid && s00_axi_bready))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The PS wins a bank only in an *_ARB cycle without collision; otherwise cpu_bank follows the CPU.
  always_comb begin
    mem_addr = '0;
    mem_ce   = '0;
    mem_we   = '0;
    mem_d    = '0;
    cpu_q    = '0;
    ps_q     = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (ps_grant && bank_reg == 4'(b)) begin
        mem_addr[b*ADDR_WIDTH +: ADDR_WIDTH] = addr_reg;
        mem_ce[b]                            = 1'b1;
        mem_we[b]                            = (state == WR_ARB);
        mem_d[b*DATA_WIDTH +: DATA_WIDTH]    = wdata_reg;
      end else if (cpu_run && cpu_bank == 4'(b)) begin
        mem_addr[b*ADDR_WIDTH +: ADDR_WIDTH] = cpu_addr;
        mem_ce[b]                            = cpu_ce;
        mem_we[b]                            = cpu_we;
        mem_d[b*DATA_WIDTH +: DATA_WIDTH]    = cpu_d;
      end
      if (cpu_bank == 4'(b)) cpu_q = mem_q[b*DATA_WIDTH +: DATA_WIDTH];
      if (bank_reg == 4'(b)) ps_q  = mem_q[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (rd_off)
      OFF_CTRL:   reg_rdata = {23'd0, auto_inc, cpu_bank, 3'd0, cpu_run};
      OFF_ADDR: begin
        reg_rdata[ADDR_WIDTH-1:0] = addr_reg;
        reg_rdata[19:16]          = bank_reg;
      end
      OFF_WDATA:  reg_rdata = 32'(wdata_reg);
      OFF_STATUS: reg_rdata = {16'd0, coll_cnt, 6'd0, sticky, (state != IDLE)};
      OFF_PERF:   reg_rdata = perf_val;
      default:    reg_rdata = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      cpu_run        <= 1'b0;
      cpu_bank       <= '0;
      auto_inc       <= 1'b0;
      addr_reg       <= '0;
      bank_reg       <= '0;
      wdata_reg      <= '0;
      sticky         <= 1'b0;
      coll_cnt       <= '0;
      op_rd          <= 1'b0;
      lat_cnt        <= '0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= OKAY;
      s00_axi_rvalid <= 1'b0;
      s00_axi_rresp  <= OKAY;
      s00_axi_rdata  <= '0;
    end else begin
      if (s00_axi_bvalid && s00_axi_bready) s00_axi_bvalid <= 1'b0;
      if (s00_axi_rvalid && s00_axi_rready) s00_axi_rvalid <= 1'b0;
      if (wr_accept) begin
        if (wr_off == OFF_WDATA) begin
          wdata_reg <= DATA_WIDTH'(s00_axi_wdata);
          op_rd     <= 1'b0;
        end
        // Register writes and out-of-range bank writes answer straight away.
        if (!(wr_off == OFF_WDATA && bank_ok)) begin
          s00_axi_bvalid <= 1'b1;
          s00_axi_bresp  <= (wr_off == OFF_WDATA) ? SLVERR : OKAY;
        end
        case (wr_off)
          OFF_CTRL: begin
            cpu_run  <= s00_axi_wdata[0];
            cpu_bank <= s00_axi_wdata[7:4];
            auto_inc <= s00_axi_wdata[8];
          end
          OFF_ADDR: begin
            addr_reg <= s00_axi_wdata[ADDR_WIDTH-1:0];
            bank_reg <= s00_axi_wdata[19:16];
          end
          OFF_STATUS: begin
            if (s00_axi_wdata[1]) begin
              sticky   <= 1'b0;
              coll_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
      if (rd_accept) begin
        if (rd_off == OFF_RDATA && bank_ok) begin
          op_rd <= 1'b1;
        end else begin
          s00_axi_rvalid <= 1'b1;
          s00_axi_rdata  <= reg_rdata;
          s00_axi_rresp  <= (rd_off == OFF_RDATA) ? SLVERR : OKAY;
        end
      end
      case (state)
        WR_ARB, RD_ARB: begin
          if (collision) begin
            sticky <= 1'b1;
            if (coll_cnt != 8'hFF) coll_cnt <= coll_cnt + 8'd1;
          end else if (state == WR_ARB) begin
            s00_axi_bvalid <= 1'b1;
            s00_axi_bresp  <= OKAY;
            if (auto_inc) addr_reg <= addr_reg + 1'b1;
          end else begin
            lat_cnt <= '0;
          end
        end
        RD_LAT: begin
          lat_cnt <= lat_cnt + 2'd1;
          if (lat_done) begin
            s00_axi_rvalid <= 1'b1;
            s00_axi_rresp  <= OKAY;
            s00_axi_rdata  <= C_S_AXI_DATA_WIDTH'(ps_q);
            if (auto_inc) addr_reg <= addr_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MANO_BRIDGE_PERF_EN
  logic [31:0] perf_cnt;
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn)                     perf_cnt <= '0;
    else if (wr_accept && wr_off == OFF_PERF) perf_cnt <= '0;
    else if (cpu_run)                         perf_cnt <= perf_cnt + 32'd1;
  end
  assign perf_val = perf_cnt;
`else
  assign perf_val = '0;
`endif

endmodule

// File: tb/tb_mano_mem_axi_bridge.sv
// Bench for mano_mem_axi_bridge: register vector table, BRAM model, read scoreboard, arbitration sequences.
module tb_mano_mem_axi_bridge;

  logic        clk, rst_n;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [23:0] mem_addr;
  logic [1:0]  mem_ce, mem_we;
  logic [63:0] mem_d, mem_q;
  logic        cpu_ce, cpu_we;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_d, cpu_q;
  logic        mano_cpu_reset_n;
  logic [2:0]  dbg_state;

  mano_mem_axi_bridge dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q),
    .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_d(cpu_d), .cpu_q(cpu_q),
    .mano_cpu_reset_n(mano_cpu_reset_n), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // BRAM model: one-cycle read-first synchronous RAM per bank
  logic [31:0] bram [0:1][0:4095];
  logic [31:0] bq [0:1];
  int we_cnt [0:1];
  initial begin
    for (int b = 0; b < 2; b++) begin
      bq[b] = '0;
      we_cnt[b] = 0;
      for (int a = 0; a < 4096; a++) bram[b][a] = '0;
    end
  end
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (mem_ce[b]) begin
        if (mem_we[b]) begin
          bram[b][mem_addr[b*12 +: 12]] <= mem_d[b*32 +: 32];
          we_cnt[b] <= we_cnt[b] + 1;
        end
        bq[b] <= bram[b][mem_addr[b*12 +: 12]];
      end
    end
  end
  assign mem_q = {bq[1], bq[0]};

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];
  string       name_q[$];
  int          r_seen = 0;
  int          r_cyc = 0;
  logic [33:0] mon_exp;
  string       mon_nm;

  always @(negedge clk) begin
    if (rst_n && rvalid && rready) begin
      r_seen++;
      r_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got resp=%0d data=%h", rresp, rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_nm  = name_q.pop_front();
        if ({rresp, rdata} !== mon_exp)
          begin
            errors++;
            $display("FAIL %s got resp=%0d data=%h want resp=%0d data=%h",
                     mon_nm, rresp, rdata, mon_exp[33:32], mon_exp[31:0]);
          end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // driver tasks
  logic [1:0]  samp_ce, samp_we;
  logic [11:0] samp_addr;

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [1:0] exp_resp,
                           input string nm, output int lat);
    int hs = 0;
    bit ok = 0;
    logic [1:0] got = '0;
    lat = -1;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1; hs = cyc; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s aw_timeout got no awready want awready", nm);
      return;
    end
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; lat = cyc - hs; got = bresp; end
    end
    @(posedge clk); #1;
    if (!ok) begin
      errors++;
      $display("FAIL %s b_timeout got no bvalid want bvalid", nm);
    end else if (got !== exp_resp) begin
      errors++;
      $display("FAIL %s bresp got %0d want %0d", nm, got, exp_resp);
    end
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [33:0] exp, input string nm,
                          input int stall, output int lat);
    int hs = 0;
    int n0;
    bit ok = 0;
    lat = -1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    n0 = r_seen;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; hs = cyc; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (stall > 0) begin
      cpu_ce = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (i == 0) begin samp_ce = mem_ce; samp_we = mem_we; samp_addr = mem_addr[11:0]; end
        @(posedge clk);
      end
      #1 cpu_ce = 1'b0;
    end
    for (int i = 0; i < 50 && ok && r_seen == n0; i++) @(negedge clk);
    checks++;
    if (!ok || r_seen == n0) begin
      errors++;
      $display("FAIL %s r_timeout got no rvalid want rvalid", nm);
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end else begin
      lat = r_cyc - hs;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          is_wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n0;
    int t_aw;
    int t_ar;
    int we_before;
    bit ok;

    vecs[0]  = '{1'b0, 5'h00, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 5'h10, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 5'h04, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 5'h1C, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 5'h18, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 5'h00, 32'hFFFFFFFF, 32'h0};
    vecs[6]  = '{1'b0, 5'h00, 32'h0,        32'h000001F1};
    vecs[7]  = '{1'b1, 5'h04, 32'hFFFFFFFF, 32'h0};
    vecs[8]  = '{1'b0, 5'h04, 32'h0,        32'h000F0FFF};
    vecs[9]  = '{1'b1, 5'h1C, 32'h12345678, 32'h0};
    vecs[10] = '{1'b0, 5'h1C, 32'h0,        32'h0};
    vecs[11] = '{1'b1, 5'h00, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 5'h00, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 5'h04, 32'h0,        32'h0};
    vecs[14] = '{1'b0, 5'h04, 32'h0,        32'h0};

    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = 4'hF; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    cpu_ce = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_d = '0;
    samp_ce = '0; samp_we = '0; samp_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_cpu_reset_n", mano_cpu_reset_n, 0);
    check("rst_mem_ce", mem_ce, 0);
    check("rst_state", dbg_state, 0);
    check("rst_valids", {awready, arready, bvalid, rvalid}, 0);
    @(posedge clk); #1;

    // register table
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, 2'b00, $sformatf("vec%0d_wr", i), lat);
        check($sformatf("vec%0d_blat", i), lat, 1);
      end else begin
        axi_read(vecs[i].addr, {2'b00, vecs[i].exp}, $sformatf("vec%0d_rd", i), 0, lat);
        check($sformatf("vec%0d_rlat", i), lat, 1);
      end
    end

    // cpu_run release
    axi_write(5'h00, 32'h1, 2'b00, "t1_ctrl", lat);
    check("t1_cpu_reset_n", mano_cpu_reset_n, 1);

    // auto-increment wrap on bank 1
    axi_write(5'h00, 32'h101, 2'b00, "t2_ctrl", lat);
    axi_write(5'h04, 32'h00010FFF, 2'b00, "t2_addr", lat);
    axi_write(5'h08, 32'hDEADBEEF, 2'b00, "t2_wdata", lat);
    check("t2_wr_lat", lat, 2);
    check("t2_bram1_fff", bram[1][12'hFFF], 32'hDEADBEEF);
    check("t2_we_counts", {32'(we_cnt[1]), 32'(we_cnt[0])}, {32'd1, 32'd0});
    axi_read(5'h04, {2'b00, 32'h00010000}, "t2_addr_wrapped", 0, lat);
    axi_write(5'h04, 32'h00010FFF, 2'b00, "t2_addr2", lat);
    axi_read(5'h0C, {2'b00, 32'hDEADBEEF}, "t2_rdata", 0, lat);
    check("t2_rd_lat", lat, 3);
    axi_read(5'h04, {2'b00, 32'h00010000}, "t2_addr_after_rd", 0, lat);

    // CPU collision on the PS bank stalls the read
    axi_write(5'h00, 32'h1, 2'b00, "t3_ctrl", lat);
    axi_write(5'h10, 32'h2, 2'b00, "t3_clr", lat);
    axi_write(5'h04, 32'h00000005, 2'b00, "t3_addr", lat);
    axi_write(5'h08, 32'hA5A50005, 2'b00, "t3_wdata", lat);
    cpu_addr = 12'h006;
    axi_read(5'h0C, {2'b00, 32'hA5A50005}, "t3_rdata", 5, lat);
    check("t3_stall_lat_ge6", (lat >= 6), 1);
    check("t3_cpu_owns_bank0", {samp_ce[0], samp_we[0], samp_addr}, {1'b1, 1'b0, 12'h006});
    axi_read(5'h10, {2'b00, 32'h00000502}, "t3_status", 0, lat);
    check("t3_cpu_q", cpu_q, 32'hA5A50005);
    axi_write(5'h10, 32'h2, 2'b00, "t3_w1c", lat);
    axi_read(5'h10, {2'b00, 32'h0}, "t3_status_clr", 0, lat);

    // CPU on bank 0, PS on bank 1: no stall
    axi_write(5'h04, 32'h00010003, 2'b00, "t4_addr", lat);
    axi_write(5'h08, 32'h11112222, 2'b00, "t4_wdata", lat);
    axi_read(5'h0C, {2'b00, 32'h11112222}, "t4_rdata", 5, lat);
    check("t4_rd_lat", lat, 3);
    axi_read(5'h10, {2'b00, 32'h0}, "t4_status", 0, lat);

    // out-of-range bank
    axi_write(5'h00, 32'h101, 2'b00, "t5_ctrl", lat);
    axi_write(5'h04, 32'h00020000, 2'b00, "t5_addr", lat);
    we_before = we_cnt[0] + we_cnt[1];
    axi_write(5'h08, 32'h00000055, 2'b10, "t5_wdata_slverr", lat);
    check("t5_wr_lat", lat, 1);
    check("t5_no_we", 32'(we_cnt[0] + we_cnt[1]), 32'(we_before));
    axi_read(5'h0C, {2'b10, 32'h0}, "t5_rdata_slverr", 0, lat);
    axi_read(5'h04, {2'b00, 32'h00020000}, "t5_addr_no_inc", 0, lat);

    // write/read tie and W1C
    axi_write(5'h00, 32'h1, 2'b00, "t6_ctrl", lat);
    axi_write(5'h04, 32'h00000005, 2'b00, "t6_addr", lat);
    axi_read(5'h0C, {2'b00, 32'hA5A50005}, "t6_stalled_rd", 2, lat);
    exp_q.push_back({2'b00, 32'h0});
    name_q.push_back("t6_status_after_w1c");
    n0 = r_seen;
    awaddr = 5'h10; wdata = 32'h2; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h10; arvalid = 1'b1;
    @(negedge clk);
    check("t6_tie_write_first", {awready, arready}, 2'b10);
    t_aw = cyc;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    ok = 0;
    t_ar = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; t_ar = cyc; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("t6_read_after_write", (ok && t_ar > t_aw), 1);
    for (int i = 0; i < 50 && r_seen == n0; i++) @(negedge clk);
    check("t6_rvalid_seen", (r_seen != n0), 1);
    @(posedge clk); #1;

    // reset during a stalled write abandons it
    axi_write(5'h00, 32'h1, 2'b00, "t7_ctrl", lat);
    cpu_ce = 1'b1;
    awaddr = 5'h08; wdata = 32'h77777777; awvalid = 1'b1; wvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (awready) ok = 1;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("t7_aw_accepted", ok, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t7_rst_abandon", {bvalid, dbg_state, mano_cpu_reset_n, mem_ce}, 0);
    cpu_ce = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    axi_read(5'h10, {2'b00, 32'h0}, "t7_status_after_rst", 0, lat);
    check("t7_no_bram_write", bram[0][12'h005], 32'hA5A50005);

    check("sb_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
